// File: rtl/mem_fill_arbiter.sv
// Arbitrates one multi-cycle memory between I-fill, D-fill and D-store; fills stream N reads, words return MEM_LATENCY later.
// Requests are level-held and only sampled in IDLE; an active fill always runs to completion.
module mem_fill_arbiter #(
  parameter int WORDS_PER_BLOCK = 8,
  parameter int MEM_LATENCY     = 4,
  parameter int ADDR_W          = 16,
  parameter int DATA_W          = 16,
  localparam int IDX_W          = $clog2(WORDS_PER_BLOCK)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_miss,
  input  logic [ADDR_W-1:0] i_miss_addr,
  input  logic              d_miss,
  input  logic [ADDR_W-1:0] d_miss_addr,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_wr_addr,
  input  logic [DATA_W-1:0] d_wr_data,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] fill_data,
  output logic [IDX_W-1:0]  fill_idx,
  output logic              i_fill_we,
  output logic              d_fill_we,
  output logic              i_fill_done,
  output logic              d_fill_done,
  output logic              d_wr_ack,
  output logic              busy
);

  localparam int CNT_W = $clog2(WORDS_PER_BLOCK + MEM_LATENCY);
  localparam logic [CNT_W-1:0]  LAST_ISS = CNT_W'(WORDS_PER_BLOCK - 1);
  localparam logic [CNT_W-1:0]  LAST_CYC = CNT_W'(WORDS_PER_BLOCK + MEM_LATENCY - 1);
  localparam logic [ADDR_W-1:0] BLK_MASK = ~ADDR_W'((1 << (IDX_W + 1)) - 1);

  typedef enum logic [1:0] {IDLE, I_FILL, D_FILL, D_WRITE} state_t;

  state_t state;
  logic [CNT_W-1:0] cnt;

  // One stage per cycle of memory latency; the last stage drives the fill outputs directly.
  logic [MEM_LATENCY-1:0]            p_i_we;
  logic [MEM_LATENCY-1:0]            p_d_we;
  logic [MEM_LATENCY-1:0]            p_i_done;
  logic [MEM_LATENCY-1:0]            p_d_done;
  logic [MEM_LATENCY-1:0][IDX_W-1:0] p_idx;

  logic issue_i;
  logic issue_d;
  logic issue_last;

  assign issue_i    = mem_en & ~mem_wr & (state == I_FILL);
  assign issue_d    = mem_en & ~mem_wr & (state == D_FILL);
  assign issue_last = (cnt == LAST_ISS);

  assign i_fill_we   = p_i_we[MEM_LATENCY-1];
  assign d_fill_we   = p_d_we[MEM_LATENCY-1];
  assign i_fill_done = p_i_done[MEM_LATENCY-1];
  assign d_fill_done = p_d_done[MEM_LATENCY-1];
  assign fill_idx    = p_idx[MEM_LATENCY-1];
  assign fill_data   = (i_fill_we | d_fill_we) ? mem_rdata : '0;
  assign busy        = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      mem_en    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      d_wr_ack  <= 1'b0;
      p_i_we    <= '0;
      p_d_we    <= '0;
      p_i_done  <= '0;
      p_d_done  <= '0;
      p_idx     <= '0;
    end else begin
      for (int j = MEM_LATENCY - 1; j > 0; j--) begin
        p_i_we[j]   <= p_i_we[j-1];
        p_d_we[j]   <= p_d_we[j-1];
        p_i_done[j] <= p_i_done[j-1];
        p_d_done[j] <= p_d_done[j-1];
        p_idx[j]    <= p_idx[j-1];
      end
      p_i_we[0]   <= issue_i;
      p_d_we[0]   <= issue_d;
      p_i_done[0] <= issue_i & issue_last;
      p_d_done[0] <= issue_d & issue_last;
      p_idx[0]    <= cnt[IDX_W-1:0];

      d_wr_ack <= 1'b0;

      case (state)
        IDLE: begin
          cnt    <= '0;
          mem_en <= 1'b0;
          mem_wr <= 1'b0;
          if (d_wr) begin
            state     <= D_WRITE;
            mem_en    <= 1'b1;
            mem_wr    <= 1'b1;
            mem_addr  <= d_wr_addr;
            mem_wdata <= d_wr_data;
            d_wr_ack  <= 1'b1;
          end else if (d_miss) begin
            state    <= D_FILL;
            mem_en   <= 1'b1;
            mem_addr <= d_miss_addr & BLK_MASK;
          end else if (i_miss) begin
            state    <= I_FILL;
            mem_en   <= 1'b1;
            mem_addr <= i_miss_addr & BLK_MASK;
          end
        end
        I_FILL, D_FILL: begin
          cnt <= cnt + 1'b1;
          if (cnt < LAST_ISS) begin
            mem_en   <= 1'b1;
            mem_addr <= mem_addr + ADDR_W'(2);
          end else begin
            mem_en   <= 1'b0;
            mem_addr <= '0;
          end
          // Reads cannot be cancelled, so leave only once the last word has returned.
          if (cnt == LAST_CYC) begin
            state <= IDLE;
            cnt   <= '0;
          end
        end
        D_WRITE: begin
          state     <= IDLE;
          mem_en    <= 1'b0;
          mem_wr    <= 1'b0;
          mem_addr  <= '0;
          mem_wdata <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_fill_arbiter.sv
// Scoreboard bench: stimulus queues expected memory ops and fill returns with their cycle; a negedge monitor pops and compares.
module tb_mem_fill_arbiter;

  typedef struct packed {
    int          cyc;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data;
  } mem_ev_t;

  typedef struct packed {
    int          cyc;
    logic        is_d;
    logic [2:0]  idx;
    logic [15:0] data;
    logic        done;
  } fill_ev_t;

  typedef struct packed {
    logic        en;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] fdata;
    logic [2:0]  idx;
    logic        iwe;
    logic        dwe;
    logic        idone;
    logic        ddone;
    logic        ack;
    logic        busy;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  logic mon_on = 1'b0;

  mem_ev_t  mq0[$], mq1[$];
  fill_ev_t fq0[$], fq1[$];

  // DUT 0: default parameters (N=8, L=4)
  logic        i_miss0, d_miss0, d_wr0;
  logic [15:0] i_miss_addr0, d_miss_addr0, d_wr_addr0, d_wr_data0;
  logic        mem_en0, mem_wr0, i_fill_we0, d_fill_we0, i_fill_done0, d_fill_done0, d_wr_ack0, busy0;
  logic [15:0] mem_addr0, mem_wdata0, mem_rdata0, fill_data0;
  logic [2:0]  fill_idx0;

  // DUT 1: MEM_LATENCY=1, only the I side is exercised
  logic        i_miss1;
  logic [15:0] i_miss_addr1;
  logic        mem_en1, mem_wr1, i_fill_we1, d_fill_we1, i_fill_done1, d_fill_done1, d_wr_ack1, busy1;
  logic [15:0] mem_addr1, mem_wdata1, mem_rdata1, fill_data1;
  logic [2:0]  fill_idx1;

  obs_t obs0, obs1;

  mem_fill_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .i_miss(i_miss0), .i_miss_addr(i_miss_addr0),
    .d_miss(d_miss0), .d_miss_addr(d_miss_addr0),
    .d_wr(d_wr0), .d_wr_addr(d_wr_addr0), .d_wr_data(d_wr_data0),
    .mem_en(mem_en0), .mem_wr(mem_wr0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
    .mem_rdata(mem_rdata0), .fill_data(fill_data0), .fill_idx(fill_idx0),
    .i_fill_we(i_fill_we0), .d_fill_we(d_fill_we0),
    .i_fill_done(i_fill_done0), .d_fill_done(d_fill_done0),
    .d_wr_ack(d_wr_ack0), .busy(busy0)
  );

  mem_fill_arbiter #(.MEM_LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .i_miss(i_miss1), .i_miss_addr(i_miss_addr1),
    .d_miss(1'b0), .d_miss_addr(16'h0),
    .d_wr(1'b0), .d_wr_addr(16'h0), .d_wr_data(16'h0),
    .mem_en(mem_en1), .mem_wr(mem_wr1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1), .fill_data(fill_data1), .fill_idx(fill_idx1),
    .i_fill_we(i_fill_we1), .d_fill_we(d_fill_we1),
    .i_fill_done(i_fill_done1), .d_fill_done(d_fill_done1),
    .d_wr_ack(d_wr_ack1), .busy(busy1)
  );

  assign obs0 = {mem_en0, mem_wr0, mem_addr0, mem_wdata0, fill_data0, fill_idx0,
                 i_fill_we0, d_fill_we0, i_fill_done0, d_fill_done0, d_wr_ack0, busy0};
  assign obs1 = {mem_en1, mem_wr1, mem_addr1, mem_wdata1, fill_data1, fill_idx1,
                 i_fill_we1, d_fill_we1, i_fill_done1, d_fill_done1, d_wr_ack1, busy1};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory contents are a fixed scramble of the address
  function automatic logic [15:0] mdat(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'hC3A5;
  endfunction

  logic [15:0] rdp0 [4];
  logic [15:0] rdp1;
  always @(posedge clk) begin
    for (int j = 3; j > 0; j--) rdp0[j] <= rdp0[j-1];
    rdp0[0] <= (mem_en0 && !mem_wr0) ? mdat(mem_addr0) : 16'h0;
    rdp1    <= (mem_en1 && !mem_wr1) ? mdat(mem_addr1) : 16'h0;
  end
  assign mem_rdata0 = rdp0[3];
  assign mem_rdata1 = rdp1;

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: actual %h required %h", nm, cyc, act, exp);
    end
  endtask

  task automatic unexpected(input string nm, input logic [95:0] act);
    n_chk++;
    n_fail++;
    $display("FAIL %s at cycle %0d: actual %h required none", nm, cyc, act);
  endtask

  task automatic mon(input int inst, input obs_t o);
    mem_ev_t  m;
    fill_ev_t f;
    int       sz;
    chk($sformatf("u%0d_invariants", inst),
        96'({o.iwe & o.dwe, o.en & ~o.busy, (o.idone | o.ddone) & ~(o.iwe | o.dwe), o.ack & ~(o.en & o.wr)}), '0);
    if (o.en) begin
      sz = (inst == 0) ? mq0.size() : mq1.size();
      if (sz == 0) unexpected($sformatf("u%0d_mem_op", inst), 96'({o.wr, o.addr}));
      else begin
        if (inst == 0) m = mq0.pop_front(); else m = mq1.pop_front();
        chk($sformatf("u%0d_mem_op", inst),
            96'({cyc, o.wr, o.ack, o.addr, o.wr ? o.wdata : 16'h0}),
            96'({m.cyc, m.wr, m.wr, m.addr, m.data}));
      end
    end
    if (o.iwe | o.dwe) begin
      sz = (inst == 0) ? fq0.size() : fq1.size();
      if (sz == 0) unexpected($sformatf("u%0d_fill", inst), 96'({o.dwe, o.idx, o.fdata}));
      else begin
        if (inst == 0) f = fq0.pop_front(); else f = fq1.pop_front();
        chk($sformatf("u%0d_fill", inst),
            96'({cyc, o.dwe, o.idx, o.fdata, o.idone, o.ddone}),
            96'({f.cyc, f.is_d, f.idx, f.data, f.done & ~f.is_d, f.done & f.is_d}));
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      mon(0, obs0);
      mon(1, obs1);
    end
  end

  // Expected traffic for one fill whose first fill cycle is g
  task automatic exp_fill(input int inst, input logic is_d, input logic [15:0] base, input int g, input int lat);
    for (int k = 0; k < 8; k++) begin
      if (inst == 0) begin
        mq0.push_back('{cyc: g + k, wr: 1'b0, addr: base + 16'(2 * k), data: 16'h0});
        fq0.push_back('{cyc: g + k + lat, is_d: is_d, idx: 3'(k), data: mdat(base + 16'(2 * k)), done: (k == 7)});
      end else begin
        mq1.push_back('{cyc: g + k, wr: 1'b0, addr: base + 16'(2 * k), data: 16'h0});
        fq1.push_back('{cyc: g + k + lat, is_d: is_d, idx: 3'(k), data: mdat(base + 16'(2 * k)), done: (k == 7)});
      end
    end
  endtask

  // Requesters drop their level request when the matching done/ack is seen
  task automatic tick();
    @(negedge clk);
    if (d_fill_done0) d_miss0 = 1'b0;
    if (i_fill_done0) i_miss0 = 1'b0;
    if (d_wr_ack0)    d_wr0   = 1'b0;
    if (i_fill_done1) i_miss1 = 1'b0;
  endtask

  task automatic wait_done(input int inst);
    for (int i = 0; i < 200; i++) begin
      tick();
      if (inst == 0 && !busy0 && !i_miss0 && !d_miss0 && !d_wr0) return;
      if (inst == 1 && !busy1 && !i_miss1) return;
    end
    unexpected($sformatf("u%0d_timeout", inst), 96'(cyc));
  endtask

  int c;

  initial begin
    rst_n = 1'b0;
    i_miss0 = 1'b0; d_miss0 = 1'b0; d_wr0 = 1'b0; i_miss1 = 1'b0;
    i_miss_addr0 = 16'h0; d_miss_addr0 = 16'h0; d_wr_addr0 = 16'h0; d_wr_data0 = 16'h0;
    i_miss_addr1 = 16'h0;
    repeat (3) tick();
    chk("u0_reset_outputs", 96'(obs0), '0);
    chk("u1_reset_outputs", 96'(obs1), '0);
    rst_n  = 1'b1;
    mon_on = 1'b1;
    tick();

    // 1: D fill at 0x1234
    c = cyc;
    d_miss0 = 1'b1; d_miss_addr0 = 16'h1234;
    exp_fill(0, 1'b1, 16'h1230, c + 1, 4);
    wait_done(0);

    // 2: simultaneous I and D misses: D first, one IDLE, then I
    c = cyc;
    i_miss0 = 1'b1; i_miss_addr0 = 16'h0100;
    d_miss0 = 1'b1; d_miss_addr0 = 16'h2468;
    exp_fill(0, 1'b1, 16'h2460, c + 1, 4);
    exp_fill(0, 1'b0, 16'h0100, c + 14, 4);
    wait_done(0);

    // 3: store raised during an I fill waits for fill + IDLE
    c = cyc;
    i_miss0 = 1'b1; i_miss_addr0 = 16'h3000;
    exp_fill(0, 1'b0, 16'h3000, c + 1, 4);
    repeat (3) tick();
    d_wr0 = 1'b1; d_wr_addr0 = 16'h0040; d_wr_data0 = 16'hBEEF;
    mq0.push_back('{cyc: c + 14, wr: 1'b1, addr: 16'h0040, data: 16'hBEEF});
    wait_done(0);

    // 4: reset during D fill cycle 3 discards in-flight reads
    c = cyc;
    d_miss0 = 1'b1; d_miss_addr0 = 16'h5550;
    for (int k = 0; k < 4; k++)
      mq0.push_back('{cyc: c + 1 + k, wr: 1'b0, addr: 16'h5550 + 16'(2 * k), data: 16'h0});
    repeat (4) tick();
    rst_n = 1'b0; d_miss0 = 1'b0;
    tick();
    chk("u0_midfill_reset_outputs", 96'(obs0), '0);
    rst_n = 1'b1;
    repeat (10) tick();

    // 5: D miss dropped after fill cycle 2 still completes
    c = cyc;
    d_miss0 = 1'b1; d_miss_addr0 = 16'h7A1E;
    exp_fill(0, 1'b1, 16'h7A10, c + 1, 4);
    repeat (3) tick();
    d_miss0 = 1'b0;
    wait_done(0);

    // 7: store beats a simultaneous D miss
    c = cyc;
    d_wr0 = 1'b1; d_wr_addr0 = 16'h0A0A; d_wr_data0 = 16'h1357;
    d_miss0 = 1'b1; d_miss_addr0 = 16'h0C08;
    mq0.push_back('{cyc: c + 1, wr: 1'b1, addr: 16'h0A0A, data: 16'h1357});
    exp_fill(0, 1'b1, 16'h0C00, c + 3, 4);
    wait_done(0);

    // 6: latency 1, I miss at 0x00FF
    c = cyc;
    i_miss1 = 1'b1; i_miss_addr1 = 16'h00FF;
    exp_fill(1, 1'b0, 16'h00F0, c + 1, 1);
    wait_done(1);
    chk("u1_idle_after_fill", 96'(busy1), '0);

    repeat (3) tick();
    chk("u0_leftover_expected", 96'(mq0.size() + fq0.size()), '0);
    chk("u1_leftover_expected", 96'(mq1.size() + fq1.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
